// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests, buffers in-order responses
// and hands {pc, enc} packets to decode. FETCH_BYPASS_EN adds a same-cycle response bypass.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [29:0] RESET_PC    = 30'h0,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstN,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [29:0] imemReqAddr,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  input  logic        imemRspErr,
  input  logic        redirectValid,
  input  logic [29:0] redirectPc,
  output logic        outValid,
  input  logic        outReady,
  output logic [61:0] out,
  output logic        outFault
);

  localparam int unsigned AW   = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned PCW  = 30;
  localparam int unsigned ENCW = 32;

  logic [PCW-1:0]  pc;
  logic            started;
  logic            halted;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   occupancy;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  logic [PCW-1:0]  q_pc    [QUEUE_DEPTH];
  logic [ENCW-1:0] q_enc   [QUEUE_DEPTH];
  logic            q_fault [QUEUE_DEPTH];

  // PCs of accepted requests, popped by every response (including discarded ones)
  logic [PCW-1:0]  pf_pc   [QUEUE_DEPTH];
  logic [AW-1:0]   pf_wr;
  logic [AW-1:0]   pf_rd;

  logic            q_empty;
  logic            credit;
  logic            req_fire;
  logic            rsp_live;
  logic            enq;
  logic            deq;
  logic [PCW-1:0]  rsp_pc;
  logic [ENCW-1:0] rsp_enc;

  assign occupancy    = wr_ptr - rd_ptr;
  assign q_empty      = (wr_ptr == rd_ptr);
  assign wr_idx       = wr_ptr[AW-1:0];
  assign rd_idx       = rd_ptr[AW-1:0];
  assign credit       = ({1'b0, inflight} + {1'b0, occupancy}) < (CW+1)'(QUEUE_DEPTH);
  assign imemReqValid = started & ~halted & credit & ~redirectValid;
  assign imemReqAddr  = pc;
  assign req_fire     = imemReqValid & imemReqReady;
  assign rsp_live     = imemRspValid & (discard == '0);
  assign rsp_pc       = pf_pc[pf_rd];
  assign rsp_enc      = imemRspErr ? '0 : imemRspData;
  assign deq          = ~q_empty & outReady & ~redirectValid;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = rsp_live & q_empty & ~redirectValid;
  assign enq    = rsp_live & ~redirectValid & ~(bypass & outReady);
`else
  assign enq    = rsp_live & ~redirectValid;
`endif

  // Packet toward decode: queue head, or the live response when bypassing an empty queue
  always_comb begin
    outValid = ~q_empty;
    out      = {q_pc[rd_idx], q_enc[rd_idx]};
    outFault = q_fault[rd_idx];
    if (q_empty) begin
      out      = '0;
      outFault = 1'b0;
    end
`ifdef FETCH_BYPASS_EN
    if (bypass) begin
      outValid = 1'b1;
      out      = {rsp_pc, rsp_enc};
      outFault = imemRspErr;
    end
`endif
  end

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire)     inflight_nxt = inflight_nxt + CW'(1);
    if (imemRspValid) inflight_nxt = inflight_nxt - CW'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc       <= RESET_PC;
      started  <= 1'b0;
      halted   <= 1'b0;
      inflight <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pf_wr    <= '0;
      pf_rd    <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        q_pc[i]    <= '0;
        q_enc[i]   <= '0;
        q_fault[i] <= 1'b0;
        pf_pc[i]   <= '0;
      end
    end else begin
      started  <= 1'b1;
      inflight <= inflight_nxt;
      if (req_fire) begin
        pf_pc[pf_wr] <= pc;
        pf_wr        <= pf_wr + AW'(1);
      end
      if (imemRspValid) pf_rd <= pf_rd + AW'(1);
      if (enq) begin
        q_pc[wr_idx]    <= rsp_pc;
        q_enc[wr_idx]   <= rsp_enc;
        q_fault[wr_idx] <= imemRspErr;
      end
      // Redirect wins: flush, and let every request still outstanding drain as stale
      if (redirectValid) begin
        pc      <= redirectPc;
        halted  <= 1'b0;
        discard <= inflight_nxt;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
      end else begin
        if (req_fire)                      pc      <= pc + PCW'(1);
        if (rsp_live & imemRspErr)         halted  <= 1'b1;
        if (imemRspValid && discard != '0) discard <= discard - CW'(1);
        if (enq)                           wr_ptr  <= wr_ptr + CW'(1);
        if (deq)                           rd_ptr  <= rd_ptr + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, corner sequences and randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [29:0] RST_PC = 30'h10;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rstN;
  logic        imemReqValid, imemReqReady;
  logic [29:0] imemReqAddr;
  logic        imemRspValid, imemRspErr;
  logic [31:0] imemRspData;
  logic        redirectValid;
  logic [29:0] redirectPc;
  logic        outValid, outReady, outFault;
  logic [61:0] out;

  fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRspValid(imemRspValid), .imemRspData(imemRspData), .imemRspErr(imemRspErr),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .outValid(outValid), .outReady(outReady), .out(out), .outFault(outFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [29:0] pc; logic [31:0] enc; logic fault; } pkt_t;
  typedef struct { logic [29:0] pc; bit stale; } req_t;
  typedef struct { int due; logic [29:0] addr; } mem_t;
  typedef struct { logic ordy; logic rv; logic [29:0] ra; logic ov; logic [29:0] opc; } vec_t;

  pkt_t mq[$];
  req_t infl[$];
  mem_t sched[$];
  logic [29:0] m_pc;
  bit m_started, m_halted;
  int cyc, lat, n_checks, n_err;
  bit fault_one_en, fault_rand_en;
  logic [29:0] fault_addr;
  logic g_rv, g_ov, g_flt;
  logic [29:0] g_ra;
  logic [61:0] g_out;
  vec_t tbl[13];
  bit found;

  function automatic logic [31:0] mem_data(input logic [29:0] a);
    return {a[15:0], 16'hBEEF ^ a[29:14]};
  endfunction

  function automatic logic is_fault(input logic [29:0] a);
    return (fault_one_en && a == fault_addr) || (fault_rand_en && a[4:0] == 5'd27);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check against the model, update it
  task automatic step(input logic redir, input logic [29:0] rpc, input logic ordy, input logic mready);
    pkt_t rp, ep;
    bit live, byp, e_rv, e_ov, credit;
    redirectValid = redir;
    redirectPc    = rpc;
    outReady      = ordy;
    imemReqReady  = mready;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      imemRspValid = 1'b1;
      imemRspData  = mem_data(sched[0].addr);
      imemRspErr   = is_fault(sched[0].addr);
      void'(sched.pop_front());
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = $urandom;
      imemRspErr   = 1'($urandom);
    end
    #1;
    g_rv = imemReqValid; g_ra = imemReqAddr; g_ov = outValid; g_out = out; g_flt = outFault;

    credit = (infl.size() + mq.size()) < int'(DEPTH);
    e_rv   = m_started && !m_halted && credit && !redir;
    live   = 1'b0;
    rp     = '{pc: 30'h0, enc: 32'h0, fault: 1'b0};
    if (imemRspValid) begin
      if (infl.size() == 0) begin
        n_checks++; n_err++;
        $display("FAIL rsp_pairing cycle=%0d got=response expected=no outstanding request", cyc);
      end else begin
        live     = !infl[0].stale;
        rp.pc    = infl[0].pc;
        rp.fault = imemRspErr;
        rp.enc   = imemRspErr ? 32'h0 : imemRspData;
      end
    end
    byp  = BYP && live && mq.size() == 0 && !redir;
    e_ov = (mq.size() > 0) || byp;
    ep   = (mq.size() > 0) ? mq[0] : rp;

    check("req_valid", 64'(g_rv), 64'(e_rv));
    check("req_addr", 64'(g_ra), 64'(m_pc));
    check("out_valid", 64'(g_ov), 64'(e_ov));
    if (e_ov) begin
      check("out_pc", 64'(g_out[61:32]), 64'(ep.pc));
      check("out_enc", 64'(g_out[31:0]), 64'(ep.enc));
      check("out_fault", 64'(g_flt), 64'(ep.fault));
    end

    if (g_rv && mready) sched.push_back('{due: cyc + lat, addr: g_ra});
    if (e_ov && ordy && !redir && mq.size() > 0) void'(mq.pop_front());
    if (imemRspValid && infl.size() > 0) begin
      void'(infl.pop_front());
      if (live && !redir) begin
        if (rp.fault) m_halted = 1'b1;
        if (!(byp && ordy)) mq.push_back(rp);
      end
    end
    if (e_rv && mready) begin
      infl.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 30'd1;
    end
    if (redir) begin
      mq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = rpc;
      m_halted = 1'b0;
    end
    m_started = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset in mid-phase; memory and model reset with it
  task automatic do_reset();
    imemReqReady = 1'b0; imemRspValid = 1'b0; imemRspData = 32'h0; imemRspErr = 1'b0;
    redirectValid = 1'b0; redirectPc = 30'h0; outReady = 1'b0;
    #2 rstN = 1'b0;
    #1;
    check("rst_req_valid", 64'(imemReqValid), 64'(0));
    check("rst_req_addr", 64'(imemReqAddr), 64'(RST_PC));
    check("rst_out_valid", 64'(outValid), 64'(0));
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_fault", 64'(outFault), 64'(0));
    sched.delete(); mq.delete(); infl.delete();
    m_pc = RST_PC; m_started = 1'b0; m_halted = 1'b0; cyc = 0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    // Back-pressure from reset, then drain: 1-cycle memory, RESET_PC 0x10
    tbl[0]  = '{1'b0, 1'b0, 30'h10, 1'b0, 30'h0};
    tbl[1]  = '{1'b0, 1'b1, 30'h10, 1'b0, 30'h0};
`ifdef FETCH_BYPASS_EN
    tbl[2]  = '{1'b0, 1'b1, 30'h11, 1'b1, 30'h10};
`else
    tbl[2]  = '{1'b0, 1'b1, 30'h11, 1'b0, 30'h0};
`endif
    tbl[3]  = '{1'b0, 1'b1, 30'h12, 1'b1, 30'h10};
    tbl[4]  = '{1'b0, 1'b1, 30'h13, 1'b1, 30'h10};
    tbl[5]  = '{1'b0, 1'b0, 30'h14, 1'b1, 30'h10};
    tbl[6]  = '{1'b0, 1'b0, 30'h14, 1'b1, 30'h10};
    tbl[7]  = '{1'b1, 1'b0, 30'h14, 1'b1, 30'h10};
    tbl[8]  = '{1'b1, 1'b1, 30'h14, 1'b1, 30'h11};
    tbl[9]  = '{1'b1, 1'b1, 30'h15, 1'b1, 30'h12};
    tbl[10] = '{1'b1, 1'b1, 30'h16, 1'b1, 30'h13};
    tbl[11] = '{1'b1, 1'b1, 30'h17, 1'b1, 30'h14};
    tbl[12] = '{1'b1, 1'b1, 30'h18, 1'b1, 30'h15};

    n_checks = 0; n_err = 0; cyc = 0; lat = 1;
    fault_one_en = 1'b0; fault_rand_en = 1'b0; fault_addr = 30'h0;
    rstN = 1'b0;
    imemReqReady = 1'b0; imemRspValid = 1'b0; imemRspData = 32'h0; imemRspErr = 1'b0;
    redirectValid = 1'b0; redirectPc = 30'h0; outReady = 1'b0;
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 30'h0, tbl[i].ordy, 1'b1);
      check("tbl_req_valid", 64'(g_rv), 64'(tbl[i].rv));
      check("tbl_req_addr", 64'(g_ra), 64'(tbl[i].ra));
      check("tbl_out_valid", 64'(g_ov), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        check("tbl_out_pc", 64'(g_out[61:32]), 64'(tbl[i].opc));
        check("tbl_out_enc", 64'(g_out[31:0]), 64'(mem_data(tbl[i].opc)));
      end
    end

    // Redirect with three stale responses outstanding (3-cycle memory)
    do_reset();
    lat = 3;
    repeat (4) step(1'b0, 30'h0, 1'b1, 1'b1);
    step(1'b1, 30'h200, 1'b1, 1'b1);
    check("redir_blocks_req", 64'(g_rv), 64'(0));
    step(1'b0, 30'h0, 1'b1, 1'b1);
    check("redir_next_req_valid", 64'(g_rv), 64'(1));
    check("redir_next_req_addr", 64'(g_ra), 64'(30'h200));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 30'h0, 1'b1, 1'b1);
      if (g_ov) begin
        found = 1'b1;
        check("redir_first_pc", 64'(g_out[61:32]), 64'(30'h200));
      end
    end
    check("redir_first_seen", 64'(found), 64'(1));

    // Response and redirect in the same cycle (1-cycle memory)
    do_reset();
    lat = 1;
    repeat (5) step(1'b0, 30'h0, 1'b1, 1'b1);
    step(1'b1, 30'h300, 1'b1, 1'b1);
    step(1'b0, 30'h0, 1'b1, 1'b1);
    check("sc_req_valid", 64'(g_rv), 64'(1));
    check("sc_req_addr", 64'(g_ra), 64'(30'h300));
    step(1'b0, 30'h0, 1'b1, 1'b1);
`ifdef FETCH_BYPASS_EN
    check("sc_bypass_valid", 64'(g_ov), 64'(1));
    check("sc_bypass_pc", 64'(g_out[61:32]), 64'(30'h300));
`else
    check("sc_queue_latency", 64'(g_ov), 64'(0));
    step(1'b0, 30'h0, 1'b1, 1'b1);
    check("sc_out_valid", 64'(g_ov), 64'(1));
    check("sc_out_pc", 64'(g_out[61:32]), 64'(30'h300));
`endif

    // Fault at 0x40 halts fetch until a redirect
    do_reset();
    lat = 1; fault_one_en = 1'b1; fault_addr = 30'h40;
    step(1'b0, 30'h0, 1'b1, 1'b1);
    step(1'b1, 30'h3C, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 30'h0, 1'b1, 1'b1);
      if (g_ov && g_out[61:32] == 30'h40) begin
        found = 1'b1;
        check("fault_flag", 64'(g_flt), 64'(1));
        check("fault_enc_zero", 64'(g_out[31:0]), 64'(0));
      end
    end
    check("fault_seen", 64'(found), 64'(1));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 30'h0, 1'b1, 1'b1);
      check("fault_halt_no_req", 64'(g_rv), 64'(0));
    end
    step(1'b1, 30'h80, 1'b1, 1'b1);
    check("fault_redir_blocks", 64'(g_rv), 64'(0));
    step(1'b0, 30'h0, 1'b1, 1'b1);
    check("fault_resume_valid", 64'(g_rv), 64'(1));
    check("fault_resume_addr", 64'(g_ra), 64'(30'h80));
    step(1'b0, 30'h0, 1'b1, 1'b1);
`ifdef FETCH_BYPASS_EN
    check("bypass_same_cycle", 64'(g_ov), 64'(1));
    check("bypass_pc", 64'(g_out[61:32]), 64'(30'h80));
    check("bypass_enc", 64'(g_out[31:0]), 64'(mem_data(30'h80)));
`else
    check("resume_queue_latency", 64'(g_ov), 64'(0));
    step(1'b0, 30'h0, 1'b1, 1'b1);
    check("resume_out_valid", 64'(g_ov), 64'(1));
    check("resume_out_pc", 64'(g_out[61:32]), 64'(30'h80));
    check("resume_out_fault", 64'(g_flt), 64'(0));
`endif
    fault_one_en = 1'b0;

    // Randomized traffic: latency, back-pressure, redirects (some near the pc wrap) and faults
    for (int ph = 0; ph < 6; ph++) begin
      lat = 1 + ph % 3;
      fault_rand_en = (ph >= 3);
      for (int i = 0; i < 300; i++) begin
        logic r;
        logic [29:0] rp;
        r  = ($urandom_range(99) < 4);
        rp = ($urandom_range(7) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
        step(r, rp, ($urandom_range(3) != 0) || ph == 0, ($urandom_range(3) != 0) || ph == 1);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 30'h0, 1'b1, 1'b0);
    end
    fault_rand_en = 1'b0;

    // Reset in the middle of traffic, then restart
    lat = 1;
    repeat (3) step(1'b0, 30'h0, 1'b0, 1'b1);
    do_reset();
    repeat (6) step(1'b0, 30'h0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
